// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: launches imem reads at current_pc and queues the returned
// words for decode, keeping FIFO entries plus in-flight reads within BUF_DEPTH.
module fetch_buffer #(
   parameter int unsigned BUF_DEPTH  = 2,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] current_pc,
   output logic                  enable_pc,
   input  logic                  do_flush_REG1,
   input  logic                  do_hazard,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  inst_valid,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic [ADDR_WIDTH-1:0] inst_pc
);

   localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] req_addr_q;
   logic                  launch_q;
   logic [ADDR_WIDTH-1:0] pc_mem_q   [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_q [BUF_DEPTH];
   logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]       count_q, count_d, count_after;
   logic                  push, pop, credit_ok, launch;

   always_comb begin
      push        = (state_q == StWait) && imem_ready && !do_flush_REG1;
      pop         = (count_q != '0) && !do_hazard && !do_flush_REG1;
      count_after = count_q + CntW'(push) - CntW'(pop);
      // A new launch needs one free slot once this edge's push/pop has settled.
      credit_ok   = count_after < CntW'(BUF_DEPTH);
      launch      = ((state_q == StIdle) || ((state_q == StWait) && imem_ready)) &&
                    credit_ok && !do_hazard && !do_flush_REG1;
      count_d     = do_flush_REG1 ? '0 : count_after;

      state_d = state_q;
      unique case (state_q)
         StIdle: if (launch) state_d = StWait;
         StWait: begin
            if (do_flush_REG1)   state_d = imem_ready ? StIdle : StDrop;
            else if (imem_ready) state_d = launch ? StWait : StIdle;
         end
         StDrop: if (imem_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         req_addr_q <= '0;
         launch_q   <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            data_mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         launch_q <= launch;
         count_q  <= count_d;
         if (launch) req_addr_q <= current_pc;
         if (push) begin
            pc_mem_q[wr_ptr_q]   <= req_addr_q;
            data_mem_q[wr_ptr_q] <= imem_rdata;
            wr_ptr_q             <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_flush_REG1) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end
      end
   end

   assign imem_req    = (state_q != StIdle);
   assign imem_addr   = req_addr_q;
   // The PC unit advances once per launch and loads the branch target on a flush.
   assign enable_pc   = !reset && (launch_q || do_flush_REG1);
   assign inst_valid  = (count_q != '0);
   assign instruction = data_mem_q[rd_ptr_q];
   assign inst_pc     = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized scoreboard bench for fetch_buffer with a PC-unit model and a variable-latency
// instruction memory; expected words follow program order from reset and flush targets.
module tb_fetch_buffer;

   localparam int unsigned Depth = 2;

   logic        clock, reset, enable_pc, do_flush_REG1, do_hazard;
   logic        imem_req, imem_ready, inst_valid;
   logic [9:0]  current_pc, imem_addr, inst_pc, flush_target;
   logic [31:0] imem_rdata, instruction;

   fetch_buffer #(.BUF_DEPTH(Depth), .ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .current_pc   (current_pc),
      .enable_pc    (enable_pc),
      .do_flush_REG1(do_flush_REG1),
      .do_hazard    (do_hazard),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .inst_valid   (inst_valid),
      .instruction  (instruction),
      .inst_pc      (inst_pc)
   );

   typedef struct packed {
      logic [9:0]  pc;
      logic [31:0] data;
   } ent_t;

   ent_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   n_pops = 0;
   int   lat_cfg = 0;
   int   cur_lat = 0;
   int   wait_cnt = 0;
   logic drop_pending = 1'b0;
   logic cap_reset = 1'b1, cap_flush = 1'b0, cap_req = 1'b0, cap_ready = 1'b0, cap_done = 1'b0;
   logic [9:0]  cap_addr = '0;
   logic [31:0] cap_data = '0;

   function automatic logic [31:0] mem_fn(input logic [9:0] a);
      return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ {22'h0, a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // PC unit: acts on the falling edge.
   initial begin
      current_pc = '0;
      forever begin
         @(negedge clock);
         if (reset) current_pc = '0;
         else if (enable_pc) current_pc = do_flush_REG1 ? flush_target : current_pc + 10'd4;
      end
   end

   // One clock: retire the previous edge into the scoreboard, then drive the next inputs.
   task automatic cycle(input logic rst, input logic fl, input logic [9:0] tgt, input logic hz);
      @(posedge clock);
      #1;
      if (cap_reset) begin
         q.delete();
         drop_pending = 1'b0;
      end else begin
         if (cap_done) begin
            if (cap_flush || drop_pending) drop_pending = 1'b0;
            else q.push_back({cap_addr, cap_data});
         end
         if (cap_flush) begin
            q.delete();
            if (cap_req && !cap_ready) drop_pending = 1'b1;
         end
      end
      reset         = rst;
      do_flush_REG1 = fl;
      flush_target  = tgt;
      do_hazard     = hz;
      if (!imem_req || cap_done || cap_reset || !cap_req) begin
         wait_cnt = 0;
         cur_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end else begin
         wait_cnt++;
      end
      imem_ready = imem_req && (wait_cnt >= cur_lat);
      imem_rdata = imem_ready ? mem_fn(imem_addr) : $urandom;
      @(negedge clock);
      cap_reset = reset;
      cap_flush = do_flush_REG1;
      cap_req   = imem_req;
      cap_ready = imem_ready;
      cap_done  = imem_req && imem_ready;
      cap_addr  = imem_addr;
      cap_data  = imem_rdata;
   endtask

   // Monitor: pops the scoreboard whenever decode consumes the head.
   logic [9:0] fetch_pc, prog_pc, prev_addr;
   logic       prev_req, prev_ready, prev_reset, new_req, exp_en;
   ent_t       e;
   int         inflight;
   initial begin
      fetch_pc = '0; prog_pc = '0; prev_addr = '0;
      prev_req = 1'b0; prev_ready = 1'b0; prev_reset = 1'b1;
      forever begin
         @(negedge clock);
         chk("inst_valid_vs_model", inst_valid, q.size() != 0);
         if (prev_reset) begin
            chk("post_reset_imem_req", imem_req, 0);
            chk("post_reset_inst_valid", inst_valid, 0);
            chk("post_reset_imem_addr", imem_addr, 0);
            chk("post_reset_inst_pc", inst_pc, 0);
            chk("post_reset_instruction", instruction, 0);
         end
         if (prev_req && !prev_ready && !prev_reset) begin
            chk("req_held", imem_req, 1);
            chk("addr_stable", imem_addr, prev_addr);
         end
         new_req = imem_req && !prev_reset && (!prev_req || prev_ready);
         exp_en  = !reset && (do_flush_REG1 || new_req);
         chk("enable_pc", enable_pc, exp_en);
         if (new_req) begin
            chk("fetch_addr", imem_addr, fetch_pc);
            fetch_pc = fetch_pc + 10'd4;
         end
         inflight = (imem_req && !drop_pending) ? 1 : 0;
         chk("credit", 64'(q.size() + inflight <= Depth), 1);
         if (!reset && !do_flush_REG1 && inst_valid && !do_hazard && q.size() != 0) begin
            e = q.pop_front();
            n_pops++;
            chk("inst_pc", inst_pc, e.pc);
            chk("instruction", instruction, e.data);
            chk("program_order", inst_pc, prog_pc);
            prog_pc = prog_pc + 10'd4;
         end
         if (reset) begin
            fetch_pc = '0;
            prog_pc  = '0;
         end else if (do_flush_REG1) begin
            fetch_pc = flush_target;
            prog_pc  = flush_target;
         end
         prev_req   = imem_req;
         prev_ready = imem_ready;
         prev_reset = reset;
         prev_addr  = imem_addr;
      end
   end

   task automatic wait_pending(input string name);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(1'b0, 1'b0, 10'h0, 1'b0);
         if (imem_req && !imem_ready) found = 1'b1;
      end
      chk(name, found, 1);
   endtask

   int p0;
   logic       r_rst, r_fl, r_hz;
   logic [9:0] r_tgt;
   initial begin
      reset = 1'b1; do_flush_REG1 = 1'b0; do_hazard = 1'b0; flush_target = '0;
      imem_ready = 1'b0; imem_rdata = '0;
      repeat (3) cycle(1'b1, 1'b0, 10'h0, 1'b0);

      // Zero-wait stream.
      lat_cfg = 0;
      p0 = n_pops;
      repeat (12) cycle(1'b0, 1'b0, 10'h0, 1'b0);
      chk("stream_throughput", 64'(n_pops - p0 >= 8), 1);

      // Decode stall fills the buffer and stops requests.
      repeat (4) cycle(1'b0, 1'b0, 10'h0, 1'b1);
      chk("hazard_req_low", imem_req, 0);
      chk("hazard_head_valid", inst_valid, 1);
      repeat (8) cycle(1'b0, 1'b0, 10'h0, 1'b0);

      // Slow memory.
      lat_cfg = 3;
      repeat (12) cycle(1'b0, 1'b0, 10'h0, 1'b0);

      // Flush while a read is pending.
      wait_pending("wait_pending_before_flush");
      cycle(1'b0, 1'b1, 10'h040, 1'b0);
      cycle(1'b0, 1'b0, 10'h0, 1'b0);
      chk("flush_clears_fifo", inst_valid, 0);
      repeat (14) cycle(1'b0, 1'b0, 10'h0, 1'b0);

      // Flush on the same edge as a completion.
      lat_cfg = 0;
      repeat (6) cycle(1'b0, 1'b0, 10'h0, 1'b0);
      cycle(1'b0, 1'b1, 10'h080, 1'b0);
      cycle(1'b0, 1'b0, 10'h0, 1'b0);
      chk("flush_ready_clears_fifo", inst_valid, 0);
      repeat (8) cycle(1'b0, 1'b0, 10'h0, 1'b0);

      // Reset while a read is pending.
      lat_cfg = 3;
      wait_pending("wait_pending_before_reset");
      cycle(1'b1, 1'b0, 10'h0, 1'b0);
      cycle(1'b0, 1'b0, 10'h0, 1'b0);
      chk("reset_drops_req", imem_req, 0);
      repeat (10) cycle(1'b0, 1'b0, 10'h0, 1'b0);

      // Random traffic.
      lat_cfg = -1;
      for (int i = 0; i < 600; i++) begin
         r_rst = ($urandom_range(0, 99) < 1);
         r_fl  = !r_rst && ($urandom_range(0, 99) < 6);
         r_hz  = ($urandom_range(0, 3) == 0);
         r_tgt = 10'($urandom_range(0, 255) << 2);
         cycle(r_rst, r_fl, r_tgt, r_hz);
      end
      repeat (6) cycle(1'b0, 1'b0, 10'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
